bpm_display_driver: RTL and testbench
=====================================

Name: bpm_display_driver

Overview:
Downstream consumer of the pulse monitor's BCD digits pd0..pd3 and single-pulsed beat strobe. Drives a 4-digit common-anode seven-segment display with time-multiplexed scanning and frame-synchronous capture, so digits never tear mid-scan. Blanks leading zeros and lights a beat indicator on the decimal point. Raises and blinks an alarm when the displayed BPM leaves the configured range.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (1 ms at 100 MHz)
BLINK_DIV, 25000000, clk cycles per blink half-period
BEAT_HOLD, 10000000, clk cycles the dp stays lit after a beat
LOW_BPM, 50, alarm when valid BPM < LOW_BPM
HIGH_BPM, 120, alarm when valid BPM > HIGH_BPM

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-low
pd0  in  4  BCD ones
pd1  in  4  BCD tens
pd2  in  4  BCD hundreds
pd3  in  4  BCD thousands
beat  in  1  single-cycle beat strobe (already single-pulsed upstream)
an  out  4  digit enables, active-low, an[0] = ones digit
seg  out  7  segments, active-low, {g,f,e,d,c,b,a}
dp  out  1  decimal point, active-low
alarm  out  1  BPM out of range, active-high, level

Behaviour:
- Reset (rst==0 at posedge): an=4'b1111, seg=7'h7F, dp=1, alarm=0; prescaler, digit index, blink counter/phase, beat-hold counter and shadow digits all 0; blink phase = ON.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. tick = (count==REFRESH_DIV-1).
- Digit index idx (2 bits) increments on tick, 3->0 wraps.
- Shadow capture: on a tick with idx==3, sh0..sh3 <= pd0..pd3. This is the only load point. Inputs changing at any other time have no effect until the next frame.
- Output stage is registered. an/seg/dp reflect the idx and shadow state of the previous cycle. One-hot low: an = ~(1<<idx), except when blanked (below).
- Segment codes: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex). Any nibble >9 shows dash = 3F.
- Leading-zero blanking applies to the digit in slot idx:
  - digit3 blanks if sh3==0;
  - digit2 blanks if sh3==sh2==0;
  - digit1 blanks if sh3..sh1 all 0;
  - digit0 is never blanked.
  - A blanked digit gives an=4'b1111, seg=7F.
- BPM value: bpm = 100*sh2 + 10*sh1 + sh0, 10-bit unsigned, computed from the shadow.
  - valid = shadow nonzero and all nibbles <=9. Zero means no reading.
  - sh3!=0 (and valid) counts as above range.
- alarm registers valid && (bpm<LOW_BPM || bpm>HIGH_BPM || sh3!=0). It updates the cycle after a shadow load and is stable between loads.
- Blink:
  - Free-running counter 0..BLINK_DIV-1; the phase toggles at wrap.
  - While alarm==1 and phase==OFF, an=4'b1111 and dp=1.
  - When alarm falls, the display shows on the next cycle regardless of phase.
- Beat indicator:
  - beat==1 loads the hold counter with BEAT_HOLD.
  - The counter decrements to 0.
  - dp=0 only while the counter is nonzero AND idx==0 AND not blink-blanked.
  - A beat during a hold reloads the counter (retrigger). A beat coinciding with rst==0 is ignored.
- Simultaneous events: a tick with idx==3 loads the shadow and advances idx to 0 in the same cycle. The first displayed frame uses the new shadow.
- Mid-operation reset forces every state and output to its reset value on that edge. Scanning restarts at idx 0.

Test Plan:
(Test parameters: REFRESH_DIV=4, BLINK_DIV=16, BEAT_HOLD=8, LOW_BPM=50, HIGH_BPM=120.)
1. Reset, then pd={0,0,7,2} held -> after the first full frame: slot0 an=1110 seg=24; slot1 an=1101 seg=78; slots 2 and 3 an=1111; alarm=0; idx advances every 4 cycles.
2. Change pd from 072 to 095 while idx==1 -> display keeps 72 until the tick at idx==3, then shows 95. No mixed frame.
3. pd={0,1,3,0} (130) -> alarm=1 one cycle after load. an stays 1111 for 16 cycles then scans for 16, repeating. Then pd=080 -> alarm=0 next load and the display is steady.
4. pd=000 -> slot0 shows seg=40, other slots blank, alarm=0. pd=045 -> alarm=1. pd nibble A -> dash 3F in that slot, alarm=0.
5. beat pulse, then beat again 5 cycles later -> dp=0 only in idx==0 slots, for 8 cycles after the second beat. dp=1 otherwise.
6. Assert rst mid-frame with alarm=1 -> next edge: an=1111, seg=7F, dp=1, alarm=0. After release, scanning restarts at slot 0 showing "0".

Source files
------------

// File: rtl/bpm_display_driver.sv
// Scans four BCD digits onto a common-anode 7-seg display with frame-synchronous capture,
// leading-zero blanking, a beat indicator on dp, and a blinking out-of-range alarm.
module bpm_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000,
  parameter int BEAT_HOLD   = 10000000,
  parameter int LOW_BPM     = 50,
  parameter int HIGH_BPM    = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pd0,
  input  logic [3:0] pd1,
  input  logic [3:0] pd2,
  input  logic [3:0] pd3,
  input  logic       beat,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       alarm
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int HW = $clog2(BEAT_HOLD + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(BEAT_HOLD);
  localparam logic          PHASE_ON   = 1'b0;
  localparam logic          PHASE_OFF  = 1'b1;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [3:0]    sh0, sh1, sh2, sh3;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic [HW-1:0] hold;

  logic          tick;
  logic          blink_wrap;
  logic          frame_load;
  logic [9:0]    bpm;
  logic          all_bcd;
  logic          valid;
  logic          alarm_next;
  logic [3:0]    digit;
  logic          blank;
  logic          blink_off;
  logic [6:0]    code;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign tick       = (presc == PRESC_LAST);
  assign blink_wrap = (blink_cnt == BLINK_LAST);
  assign frame_load = tick && (idx == 2'd3);

  assign bpm     = 10'(sh2) * 10'd100 + 10'(sh1) * 10'd10 + 10'(sh0);
  assign all_bcd = (sh0 <= 4'd9) && (sh1 <= 4'd9) && (sh2 <= 4'd9) && (sh3 <= 4'd9);
  assign valid   = (|{sh3, sh2, sh1, sh0}) && all_bcd;
  // A nonzero thousands digit is always above any sane range.
  assign alarm_next = valid && ((bpm < 10'(LOW_BPM)) || (bpm > 10'(HIGH_BPM)) || (sh3 != 4'd0));

  assign blink_off = alarm && (phase == PHASE_OFF);

  always_comb begin
    digit = sh0;
    blank = 1'b0;
    case (idx)
      2'd0: begin digit = sh0; blank = 1'b0; end
      2'd1: begin digit = sh1; blank = (sh3 == 4'd0) && (sh2 == 4'd0) && (sh1 == 4'd0); end
      2'd2: begin digit = sh2; blank = (sh3 == 4'd0) && (sh2 == 4'd0); end
      default: begin digit = sh3; blank = (sh3 == 4'd0); end
    endcase
  end

  always_comb begin
    code = 7'h3F;
    case (digit)
      4'd0: code = 7'h40;
      4'd1: code = 7'h79;
      4'd2: code = 7'h24;
      4'd3: code = 7'h30;
      4'd4: code = 7'h19;
      4'd5: code = 7'h12;
      4'd6: code = 7'h02;
      4'd7: code = 7'h78;
      4'd8: code = 7'h00;
      4'd9: code = 7'h10;
      default: code = 7'h3F;
    endcase
  end

  always_comb begin
    an_next  = (blank || blink_off) ? 4'b1111 : ~(4'b0001 << idx);
    seg_next = blank ? 7'h7F : code;
    dp_next  = !((hold != '0) && (idx == 2'd0) && !blink_off);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc     <= '0;
      idx       <= 2'd0;
      sh0       <= 4'd0;
      sh1       <= 4'd0;
      sh2       <= 4'd0;
      sh3       <= 4'd0;
      blink_cnt <= '0;
      phase     <= PHASE_ON;
      hold      <= '0;
      alarm     <= 1'b0;
      an        <= 4'b1111;
      seg       <= 7'h7F;
      dp        <= 1'b1;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick)
        idx <= idx + 2'd1;
      // Only load point: last slot of a frame, so a frame never mixes old and new digits.
      if (frame_load) begin
        sh0 <= pd0;
        sh1 <= pd1;
        sh2 <= pd2;
        sh3 <= pd3;
      end
      alarm     <= alarm_next;
      blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      if (blink_wrap)
        phase <= ~phase;
      if (beat)
        hold <= HOLD_LOAD;
      else if (hold != '0)
        hold <= hold - 1'b1;
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_bpm_display_driver.sv
// Directed and random stimulus for bpm_display_driver, checked each cycle against a
// time-indexed reference model (slot, blink phase and hold derived from cycles since reset).
module tb_bpm_display_driver;

  localparam int R  = 4;
  localparam int B  = 16;
  localparam int BH = 8;
  localparam int LO = 50;
  localparam int HI = 120;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] pd0 = 4'd0, pd1 = 4'd0, pd2 = 4'd0, pd3 = 4'd0;
  logic       beat = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       alarm;

  bpm_display_driver #(
    .REFRESH_DIV(R), .BLINK_DIV(B), .BEAT_HOLD(BH), .LOW_BPM(LO), .HIGH_BPM(HI)
  ) dut (
    .clk(clk), .rst(rst), .pd0(pd0), .pd1(pd1), .pd2(pd2), .pd3(pd3),
    .beat(beat), .an(an), .seg(seg), .dp(dp), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: edges since reset, displayed digits, alarm level, edge of the last beat.
  int         n = 0;
  int         msh[4] = '{0, 0, 0, 0};
  bit         malarm = 1'b0;
  int         last_beat = -1;
  logic [3:0] e_an  = 4'b1111;
  logic [6:0] e_seg = 7'h7F;
  logic       e_dp  = 1'b1;
  logic [6:0] segtab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic bit alarm_of(input int s0, input int s1, input int s2, input int s3);
    int  bpm;
    bit  ok;
    ok  = (s0 + s1 + s2 + s3 != 0) && s0 <= 9 && s1 <= 9 && s2 <= 9 && s3 <= 9;
    bpm = 100 * s2 + 10 * s1 + s0;
    return ok && (bpm < LO || bpm > HI || s3 != 0);
  endfunction

  task automatic set_pd(input int d3, input int d2, input int d1, input int d0);
    pd3 = 4'(d3); pd2 = 4'(d2); pd1 = 4'(d1); pd0 = 4'(d0);
  endtask

  task automatic step();
    int  slot, hold;
    bit  boff, blank, na;
    @(posedge clk);
    if (!rst) begin
      n = 0; msh = '{0, 0, 0, 0}; malarm = 1'b0; last_beat = -1;
      e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      slot = (n / R) % 4;
      boff = malarm && (((n / B) % 2) == 1);
      hold = (last_beat < 0) ? 0 : BH - (n - last_beat);
      if (hold < 0) hold = 0;
      blank = (slot > 0);
      for (int j = slot; j < 4; j++)
        if (msh[j] != 0) blank = 1'b0;
      e_an  = (blank || boff) ? 4'b1111 : ~(4'b0001 << slot);
      e_seg = blank ? 7'h7F : (msh[slot] > 9 ? 7'h3F : segtab[msh[slot]]);
      e_dp  = !(hold > 0 && slot == 0 && !boff);
      na = alarm_of(msh[0], msh[1], msh[2], msh[3]);
      if (n % (4 * R) == 4 * R - 1)
        msh = '{int'(pd0), int'(pd1), int'(pd2), int'(pd3)};
      malarm = na;
      if (beat) last_beat = n + 1;
      n++;
    end
    #1;
    checks++;
    assert (an === e_an) else begin
      errors++; $error("FAIL an n=%0d observed=%b expected=%b", n, an, e_an);
    end
    checks++;
    assert (seg === e_seg) else begin
      errors++; $error("FAIL seg n=%0d observed=%h expected=%h", n, seg, e_seg);
    end
    checks++;
    assert (dp === e_dp) else begin
      errors++; $error("FAIL dp n=%0d observed=%b expected=%b", n, dp, e_dp);
    end
    checks++;
    assert (alarm === malarm) else begin
      errors++; $error("FAIL alarm n=%0d observed=%b expected=%b", n, alarm, malarm);
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    step();
    beat = 1'b0;
  endtask

  initial begin
    // 1: reset, then 72 held
    set_pd(0, 0, 7, 2);
    run(3);
    rst = 1'b1;
    run(40);
    // 2: change to 95 while slot 1 is showing
    while (((n / R) % 4) != 1) step();
    set_pd(0, 0, 9, 5);
    run(40);
    // 3: 130 alarms and blinks, then 80 clears it
    set_pd(0, 1, 3, 0);
    run(80);
    set_pd(0, 0, 8, 0);
    run(40);
    // 4: zero, low, non-BCD nibble
    set_pd(0, 0, 0, 0);
    run(24);
    set_pd(0, 0, 4, 5);
    run(24);
    set_pd(0, 0, 10, 5);
    run(24);
    set_pd(1, 0, 7, 2);
    run(24);
    // 5: beat, retrigger 5 cycles later
    set_pd(0, 0, 7, 2);
    run(20);
    pulse_beat();
    run(4);
    pulse_beat();
    run(30);
    // 6: mid-frame reset while alarmed, with a beat on the reset edge
    set_pd(0, 1, 3, 0);
    run(40);
    while ((n % R) != 1) step();
    rst = 1'b0;
    beat = 1'b1;
    step();
    beat = 1'b0;
    rst = 1'b1;
    run(24);
    // random soak
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 3) == 0)
          set_pd($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        else
          set_pd(($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(0, 2),
                 $urandom_range(0, 9), $urandom_range(0, 9));
      end
      beat = ($urandom_range(0, 9) == 0);
      rst  = ($urandom_range(0, 199) != 0);
      step();
    end
    beat = 1'b0;
    rst  = 1'b1;
    run(8);
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
